seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl_pkg.sv | 26 ++
 rtl/bit_pattern_fsm.sv | 54 +++++
 rtl/seq_det_ctrl.sv | 97 +++++++++
 tb/tb_seq_det_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_ctrl_pkg.sv
// Shared encodings for the word scanner: controller states, the two
// detector state sets, and the default word width.
package seq_det_ctrl_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    X0 = 2'd0,
    X1 = 2'd1,
    X2 = 2'd2,
    X3 = 2'd3
  } x_state_t;

  typedef enum logic [1:0] {
    Y0 = 2'd0,
    Y1 = 2'd1,
    Y2 = 2'd2
  } y_state_t;

endpackage

// File: rtl/bit_pattern_fsm.sv
// Serial bit detector: x saturates after three 1 bits, y tracks a run of
// two or more adjacent 1 bits. clr has priority over en.
module bit_pattern_fsm
  import seq_det_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic a,
  output logic x,
  output logic y_now
);

  x_state_t x_state, x_next;
  y_state_t y_state, y_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_state <= X0;
      y_state <= Y0;
    end else begin
      x_state <= x_next;
      y_state <= y_next;
    end
  end

  always_comb begin
    x_next = x_state;
    y_next = y_state;
    if (clr) begin
      x_next = X0;
      y_next = Y0;
    end else if (en) begin
      if (a) begin
        case (x_state)
          X0:      x_next = X1;
          X1:      x_next = X2;
          default: x_next = X3;
        endcase
        case (y_state)
          Y0:      y_next = Y1;
          default: y_next = Y2;
        endcase
      end else begin
        y_next = Y0;
      end
    end
  end

  assign x     = (x_state == X3);
  assign y_now = (y_state == Y2);

endmodule

// File: rtl/seq_det_ctrl.sv
// Word scanner: accepts a word in IDLE, shifts it LSB first through the
// pattern detector, then pulses done for one cycle with the results.
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [W-1:0]               din,
  output logic                       busy,
  output logic                       done,
  output logic                       x_flag,
  output logic                       y_flag,
  output logic [$clog2(W+1)-1:0]     ones_cnt
);

  localparam int CW = $clog2(W+1);

  ctrl_state_t     state, state_next;
  logic [W-1:0]    sreg;
  logic [CW-1:0]   bit_cnt;
  logic            clr;
  logic            en;
  logic            det_x;
  logic            det_y_now;
  logic            y_sticky;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    clr        = 1'b0;
    en         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr        = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        en   = 1'b1;
        if (bit_cnt == CW'(W-1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // y must stay set once seen in this word even if a later 0 resets the detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      y_sticky <= 1'b0;
    end else if (clr) begin
      sreg     <= din;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      y_sticky <= 1'b0;
    end else begin
      y_sticky <= y_sticky | det_y_now;
      if (en) begin
        sreg     <= sreg >> 1;
        bit_cnt  <= bit_cnt + CW'(1);
        ones_cnt <= ones_cnt + {{(CW-1){1'b0}}, sreg[0]};
      end
    end
  end

  bit_pattern_fsm u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .a     (sreg[0]),
    .x     (det_x),
    .y_now (det_y_now)
  );

  assign x_flag = det_x;
  assign y_flag = y_sticky | det_y_now;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus random
// words compared against a popcount / adjacent-ones reference model.
module tb_seq_det_ctrl;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       x_flag;
  logic       y_flag;
  logic [3:0] ones_cnt;

  int errors = 0;
  int checks = 0;

  seq_det_ctrl #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .x_flag   (x_flag),
    .y_flag   (y_flag),
    .ones_cnt (ones_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: ones among the low n bits, and adjacent ones among them
  function automatic int popc(input logic [7:0] w, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (w[i]) c++;
    return c;
  endfunction

  function automatic bit adj(input logic [7:0] w, input int n);
    for (int i = 0; i + 1 < n; i++) if (w[i] && w[i+1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic scan(input logic [7:0] w, output int lat);
    @(negedge clk);
    din   = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, x_flag, y_flag} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy/done/x/y=%b required 0000", {busy, done, x_flag, y_flag});
    end
    checks++;
    if (ones_cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %0d required 0", ones_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero_word();
    int lat;
    int extra = 0;
    scan(8'h00, lat);
    checks++;
    if (lat != 9) begin
      errors++;
      $display("[TB] FAIL zero_latency: got %0d required 9", lat);
    end
    checks++;
    if ({x_flag, y_flag, ones_cnt} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL zero_result: got x=%b y=%b cnt=%0d required 0/0/0", x_flag, y_flag, ones_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_done_width: got done=%b busy=%b required 0 0", done, busy);
    end
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL zero_single_done: got %0d extra dones required 0", extra);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] words[$];
    int lat;
    int ec;
    words.push_back(8'h55);
    words.push_back(8'h03);
    for (int i = 0; i < 16; i++) words.push_back(8'($urandom));
    foreach (words[i]) begin
      scan(words[i], lat);
      ec = popc(words[i], 8);
      checks++;
      if (lat != 9) begin
        errors++;
        $display("[TB] FAIL pat_latency %h: got %0d required 9", words[i], lat);
      end
      checks++;
      if (x_flag !== (ec >= 3) || y_flag !== adj(words[i], 8) || ones_cnt !== ec[3:0]) begin
        errors++;
        $display("[TB] FAIL pat_result %h: got x=%b y=%b cnt=%0d required x=%b y=%b cnt=%0d",
                 words[i], x_flag, y_flag, ones_cnt, (ec >= 3), adj(words[i], 8), ec);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (x_flag !== (ec >= 3) || y_flag !== adj(words[i], 8) || ones_cnt !== ec[3:0]) begin
        errors++;
        $display("[TB] FAIL pat_hold %h: got x=%b y=%b cnt=%0d required x=%b y=%b cnt=%0d",
                 words[i], x_flag, y_flag, ones_cnt, (ec >= 3), adj(words[i], 8), ec);
      end
    end
  endtask

  task automatic test_live();
    logic [7:0] w;
    int ec;
    for (int r = 0; r < 3; r++) begin
      w = 8'($urandom);
      @(negedge clk);
      din   = w;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k <= 8; k++) begin
        ec = popc(w, k);
        checks++;
        if (ones_cnt !== ec[3:0] || x_flag !== (ec >= 3) || y_flag !== adj(w, k) || done !== (k == 8)) begin
          errors++;
          $display("[TB] FAIL live %h edge %0d: got x=%b y=%b cnt=%0d done=%b required x=%b y=%b cnt=%0d done=%b",
                   w, k, x_flag, y_flag, ones_cnt, done, (ec >= 3), adj(w, k), ec, (k == 8));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 1;
    int n1;
    @(negedge clk);
    din   = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    din = 8'h80;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n1 = n;
    checks++;
    if (n1 != 9 || x_flag !== 1'b1 || y_flag !== 1'b1 || ones_cnt !== 4'd8) begin
      errors++;
      $display("[TB] FAIL b2b_first: got lat=%0d x=%b y=%b cnt=%0d required 9 1 1 8", n1, x_flag, y_flag, ones_cnt);
    end
    @(negedge clk);
    n++;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle_gap: got busy=%b required 0", busy);
    end
    @(negedge clk);
    n++;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_restart: got busy=%b required 1", busy);
    end
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n - n1 != 10 || x_flag !== 1'b0 || y_flag !== 1'b0 || ones_cnt !== 4'd1) begin
      errors++;
      $display("[TB] FAIL b2b_second: got gap=%0d x=%b y=%b cnt=%0d required 10 0 0 1", n - n1, x_flag, y_flag, ones_cnt);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int n = 1;
    int dones = 0;
    int first = 0;
    logic [5:0] res = '1;
    @(negedge clk);
    din   = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n++;
    end
    din   = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    din   = 8'h00;
    while (n < 30) begin
      if (done === 1'b1) begin
        dones++;
        if (first == 0) begin
          first = n;
          res   = {x_flag, y_flag, ones_cnt};
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (dones != 1 || first != 9) begin
      errors++;
      $display("[TB] FAIL ignore_done: got dones=%0d at %0d required 1 at 9", dones, first);
    end
    checks++;
    if (res !== 6'b0) begin
      errors++;
      $display("[TB] FAIL ignore_result: got x/y/cnt=%b required 000000", res);
    end
  endtask

  task automatic test_abort();
    int lat;
    @(negedge clk);
    din   = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ones_cnt !== 4'd5) begin
      errors++;
      $display("[TB] FAIL abort_pre: got busy=%b cnt=%0d required 1 5", busy, ones_cnt);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, x_flag, y_flag, ones_cnt} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL abort_async: got busy=%b done=%b x=%b y=%b cnt=%0d required all 0",
               busy, done, x_flag, y_flag, ones_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_hold: got busy=%b done=%b required 0 0", busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    din   = 8'h07;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 9 || x_flag !== 1'b1 || y_flag !== 1'b1 || ones_cnt !== 4'd3) begin
      errors++;
      $display("[TB] FAIL abort_restart: got lat=%0d x=%b y=%b cnt=%0d required 9 1 1 3", lat, x_flag, y_flag, ones_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_zero_word();
    test_patterns();
    test_live();
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
